// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the sync_fifo_lvl family: address/count widths and
// elaboration-time parameter legality.
package sync_fifo_pkg;

  // Address width for a DEPTH-entry store, never less than one bit.
  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  // The count must represent 0..DEPTH inclusive, so it needs one bit more.
  function automatic int count_width(input int depth);
    return clog2_min1(depth) + 1;
  endfunction

  function automatic bit params_ok(input int width, input int depth,
                                   input int afull_th, input int aempty_th);
    return (width >= 1) && (depth >= 2) &&
           (afull_th <= depth) && (aempty_th < depth);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage for sync_fifo_lvl: one synchronous write port and one asynchronous
// read port, kept separate so a vendor RAM or flop array can be swapped in.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW   = clog2_min1(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; contents are only observed once written,
  // and a reset would stop it from mapping onto RAM primitives.
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/sync_fifo_lvl.sv
// Single-clock FWFT FIFO with arbitrary depth, fill level, almost-full/empty
// thresholds and guarded push/pop. Define SYNC_FIFO_LVL_ERR_EN for sticky errors.
module sync_fifo_lvl
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [WIDTH-1:0]            i_wdata,
  input  logic                        i_push,
  input  logic                        i_pop,
  input  logic                        i_flush,
  input  logic                        i_err_clr,
  output logic [WIDTH-1:0]            o_rdata,
  output logic                        o_full,
  output logic                        o_empty,
  output logic                        o_afull,
  output logic                        o_aempty,
  output logic [count_width(DEPTH)-1:0] o_count,
  output logic                        o_overflow,
  output logic                        o_underflow
);

  localparam int AW = clog2_min1(DEPTH);
  localparam int CW = count_width(DEPTH);

  if (!params_ok(WIDTH, DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
    $error("sync_fifo_lvl: illegal WIDTH/DEPTH/AFULL_TH/AEMPTY_TH combination");
  end

  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_next;
  logic             full_q, empty_q, afull_q, aempty_q;
  logic             push_ok, pop_ok, we;
  logic [WIDTH-1:0] ram_rdata;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths never leave the array.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // When full, a same-cycle pop frees the slot the push needs.
  assign push_ok = i_push & (~full_q | i_pop);
  assign pop_ok  = i_pop & ~empty_q;
  assign we      = push_ok & ~i_flush;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    count_next = count_q;
    if (i_flush) count_next = '0;
    else         count_next = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (i_flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= ptr_inc(wptr_q);
      if (pop_ok)  rptr_q <= ptr_inc(rptr_q);
    end
  end

  // Flags are registered from count_next so they always match the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= (AFULL_TH == 0);
      aempty_q <= 1'b1;
    end else begin
      count_q  <= count_next;
      full_q   <= (count_next == CW'(DEPTH));
      empty_q  <= (count_next == '0);
      afull_q  <= (count_next >= CW'(AFULL_TH));
      aempty_q <= (count_next <= CW'(AEMPTY_TH));
    end
  end

  sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (we),
    .i_waddr (wptr_q),
    .i_wdata (i_wdata),
    .i_raddr (rptr_q),
    .o_rdata (ram_rdata)
  );

  assign o_rdata  = empty_q ? '0 : ram_rdata;
  assign o_count  = count_q;
  assign o_full   = full_q;
  assign o_empty  = empty_q;
  assign o_afull  = afull_q;
  assign o_aempty = aempty_q;

`ifdef SYNC_FIFO_LVL_ERR_EN
  logic ovf_q, unf_q;

  // A new error event outranks a same-cycle clear; flush outranks both.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (i_flush) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (i_push & full_q & ~i_pop) ovf_q <= 1'b1;
      else if (i_err_clr)           ovf_q <= 1'b0;
      if (i_pop & empty_q)          unf_q <= 1'b1;
      else if (i_err_clr)           unf_q <= 1'b0;
    end
  end

  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = i_err_clr;
  assign o_overflow     = 1'b0;
  assign o_underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Bench for sync_fifo_lvl (DEPTH=5, WIDTH=8): directed vector table, an async
// reset sequence, then random traffic against a queue-based reference model.
module tb_sync_fifo_lvl;

  localparam int DEPTH = 5;
  localparam int WIDTH = 8;
  localparam int AFULL = 4;
  localparam int AEMPT = 1;
`ifdef SYNC_FIFO_LVL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] wdata;
  logic             push, pop, flush, err_clr;
  logic [WIDTH-1:0] rdata;
  logic             full, empty, afull, aempty, overflow, underflow;
  logic [3:0]       count;

  always #5 clk = ~clk;

  sync_fifo_lvl #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AFULL_TH  (AFULL),
    .AEMPTY_TH (AEMPT)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_wdata     (wdata),
    .i_push      (push),
    .i_pop       (pop),
    .i_flush     (flush),
    .i_err_clr   (err_clr),
    .o_rdata     (rdata),
    .o_full      (full),
    .o_empty     (empty),
    .o_afull     (afull),
    .o_aempty    (aempty),
    .o_count     (count),
    .o_overflow  (overflow),
    .o_underflow (underflow)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue plus the two sticky flags.
  logic [WIDTH-1:0] q[$];
  bit m_ovf, m_unf;

  task automatic model_step(input bit pu, input bit po, input bit fl, input bit ec,
                            input logic [WIDTH-1:0] d);
    bit was_full, was_empty;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (fl) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      if (ERR_EN) begin
        if (pu && was_full && !po) m_ovf = 1; else if (ec) m_ovf = 0;
        if (po && was_empty)       m_unf = 1; else if (ec) m_unf = 0;
      end
      if (po && !was_empty) void'(q.pop_front());
      if (pu && (!was_full || po)) q.push_back(d);
    end
  endtask

  // Inputs are applied after a falling edge and cleared at the next one.
  task automatic cycle(input bit pu, input bit po, input bit fl, input bit ec,
                       input logic [WIDTH-1:0] d);
    push = pu; pop = po; flush = fl; err_clr = ec; wdata = d;
    @(posedge clk);
    model_step(pu, po, fl, ec, d);
    @(negedge clk);
    push = 0; pop = 0; flush = 0; err_clr = 0; wdata = '0;
  endtask

  task automatic check_level(input string tag, input int cnt, input logic [WIDTH-1:0] rd,
                             input bit ovf, input bit unf);
    check({tag, " count"},     32'(count),     32'(cnt));
    check({tag, " empty"},     32'(empty),     32'(cnt == 0));
    check({tag, " full"},      32'(full),      32'(cnt == DEPTH));
    check({tag, " afull"},     32'(afull),     32'(cnt >= AFULL));
    check({tag, " aempty"},    32'(aempty),    32'(cnt <= AEMPT));
    check({tag, " rdata"},     32'(rdata),     32'(rd));
    check({tag, " overflow"},  32'(overflow),  32'(ovf & ERR_EN));
    check({tag, " underflow"}, 32'(underflow), 32'(unf & ERR_EN));
  endtask

  task automatic check_model(input string tag);
    check_level(tag, q.size(), (q.size() == 0) ? '0 : q[0], m_ovf, m_unf);
  endtask

  typedef struct {
    bit               pu, po, fl, ec;
    logic [WIDTH-1:0] d;
    int               cnt;
    logic [WIDTH-1:0] rd;
    bit               ovf, unf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit pu, input bit po, input bit fl, input bit ec,
                              input logic [WIDTH-1:0] d, input int cnt,
                              input logic [WIDTH-1:0] rd, input bit ovf, input bit unf);
    vec_t v;
    v.pu = pu; v.po = po; v.fl = fl; v.ec = ec; v.d = d;
    v.cnt = cnt; v.rd = rd; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; push = 0; pop = 0; flush = 0; err_clr = 0; wdata = '0;
    m_ovf = 0; m_unf = 0;

    // fill, overflow attempt, drain with pointer wrap, clear
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 8'h11 + 8'(i), i + 1, 8'h11, 0, 0);
    add(1, 0, 0, 0, 8'h16, 5, 8'h11, 1, 0);
    add(0, 1, 0, 0, 8'h00, 4, 8'h12, 1, 0);
    add(0, 1, 0, 0, 8'h00, 3, 8'h13, 1, 0);
    add(0, 1, 0, 0, 8'h00, 2, 8'h14, 1, 0);
    add(0, 1, 0, 0, 8'h00, 1, 8'h15, 1, 0);
    add(0, 1, 0, 0, 8'h00, 0, 8'h00, 1, 0);
    add(0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0);
    // full with simultaneous push + pop
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 8'h11 + 8'(i), i + 1, 8'h11, 0, 0);
    add(1, 1, 0, 0, 8'hAA, 5, 8'h12, 0, 0);
    add(0, 1, 0, 0, 8'h00, 4, 8'h13, 0, 0);
    add(0, 1, 0, 0, 8'h00, 3, 8'h14, 0, 0);
    add(0, 1, 0, 0, 8'h00, 2, 8'h15, 0, 0);
    add(0, 1, 0, 0, 8'h00, 1, 8'hAA, 0, 0);
    add(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    // empty push + pop, underflow, event beats clear, clear
    add(1, 1, 0, 0, 8'h33, 1, 8'h33, 0, 0);
    add(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    add(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1);
    add(0, 1, 0, 1, 8'h00, 0, 8'h00, 0, 1);
    add(0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0);
    // flush with push discards data and clears errors
    add(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 1);
    add(1, 0, 0, 0, 8'h41, 1, 8'h41, 0, 1);
    add(1, 0, 0, 0, 8'h42, 2, 8'h41, 0, 1);
    add(1, 0, 0, 0, 8'h43, 3, 8'h41, 0, 1);
    add(1, 0, 1, 0, 8'h44, 0, 8'h00, 0, 0);
    add(1, 0, 0, 0, 8'h55, 1, 8'h55, 0, 0);
    add(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0);

    repeat (2) @(negedge clk);
    check_level("reset", 0, 8'h00, 0, 0);
    rst_n = 1;
    @(negedge clk);

    foreach (vecs[i]) begin
      cycle(vecs[i].pu, vecs[i].po, vecs[i].fl, vecs[i].ec, vecs[i].d);
      check_level($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].rd, vecs[i].ovf, vecs[i].unf);
    end

    // async reset mid-burst, released before the next rising edge
    cycle(1, 0, 0, 0, 8'h61);
    cycle(1, 0, 0, 0, 8'h62);
    check_level("pre-rst", 2, 8'h61, 0, 0);
    #1 rst_n = 0;
    #1 check_level("async-rst", 0, 8'h00, 0, 0);
    q.delete(); m_ovf = 0; m_unf = 0;
    #1 rst_n = 1;
    @(negedge clk);
    check_level("post-rst", 0, 8'h00, 0, 0);
    cycle(1, 0, 0, 0, 8'h71);
    check_level("resume push", 1, 8'h71, 0, 0);
    cycle(1, 0, 0, 0, 8'h72);
    cycle(0, 1, 0, 0, 8'h00);
    check_level("resume pop", 1, 8'h72, 0, 0);

    // random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      bit pu, po, fl, ec;
      pu = ($urandom_range(99) < 55);
      po = ($urandom_range(99) < 45);
      fl = ($urandom_range(63) == 0);
      ec = ($urandom_range(7) == 0);
      cycle(pu, po, fl, ec, 8'($urandom));
      check_model($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
